// File: rtl/alu_operand_regfile.sv
// Register file and registered operand-issue stage feeding the ALU, with write-first bypass.
// Optional per-register busy scoreboard and Hazard flag enabled by REGFILE_SCOREBOARD_EN.
module alu_operand_regfile #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_en,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] read_addr1,
    input  logic [ADDR_WIDTH-1:0] read_addr2,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] operand_a,
    output logic [DATA_WIDTH-1:0] operand_b,
    output logic                  op_valid,
    output logic                  hazard,
    input  logic                  reserve_en,
    input  logic [ADDR_WIDTH-1:0] reserve_addr
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  write_hit;
    logic                  issue;
    logic                  refuse;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    assign write_hit = write_en && (write_addr != '0);
    assign issue     = read_en && !stall;

    // regs[0] is never written, so reads of R0 return zero without a special case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            regs[0] <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (write_hit && (write_addr == ADDR_WIDTH'(i))) regs[i] <= write_data;
            end
        end
    end

    always_comb begin
        rd_a = regs[read_addr1];
        rd_b = regs[read_addr2];
        if (write_hit && (write_addr == read_addr1)) rd_a = write_data;
        if (write_hit && (write_addr == read_addr2)) rd_b = write_data;
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy;
    logic                hazard_q;
    logic                busy_a;
    logic                busy_b;

    // Reserve beats a same-edge write so a new producer keeps ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (reserve_en && (reserve_addr == ADDR_WIDTH'(i))) busy[i] <= 1'b1;
                else if (write_hit && (write_addr == ADDR_WIDTH'(i))) busy[i] <= 1'b0;
            end
            busy[0] <= 1'b0;
        end
    end

    assign busy_a = busy[read_addr1] && !(write_hit && (write_addr == read_addr1));
    assign busy_b = busy[read_addr2] && !(write_hit && (write_addr == read_addr2));
    assign refuse = busy_a || busy_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hazard_q <= 1'b0;
        else        hazard_q <= issue && refuse;
    end

    assign hazard = hazard_q;
`else
    logic unused_reserve;
    assign unused_reserve = &{1'b0, reserve_en, reserve_addr};
    assign refuse = 1'b0;
    assign hazard = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand_a <= '0;
            operand_b <= '0;
            op_valid  <= 1'b0;
        end else if (issue && !refuse) begin
            operand_a <= rd_a;
            operand_b <= rd_b;
            op_valid  <= 1'b1;
        end else if (!stall) begin
            op_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_operand_regfile.md
Name: alu_operand_regfile

Overview:
- Register file plus operand-issue stage sitting directly upstream of the 16-slice ALU datapath.
- Holds the CPU general registers and presents a registered A/B operand pair to the ALU, with an OpValid qualifier.
- Accepts the ALU result (or any writeback value) on a single write port.
- Supports stall/hold and same-cycle write-to-read bypass, so the ALU never sees a stale operand.

Parameters:
- DATA_WIDTH, 16, width of each register and of each operand.
- ADDR_WIDTH, 2, register address width; NUM_REGS = 2**ADDR_WIDTH (4 registers, R0 to R3).

Ports:
- Clock  input  1  single system clock, rising edge.
- ResetN  input  1  asynchronous, active-low reset.
- ReadEn  input  1  request to fetch a new operand pair this cycle.
- Stall  input  1  downstream busy; hold the current operands.
- ReadAddr1  input  ADDR_WIDTH  source register for operand A.
- ReadAddr2  input  ADDR_WIDTH  source register for operand B.
- WriteEn  input  1  write strobe.
- WriteAddr  input  ADDR_WIDTH  destination register.
- WriteData  input  DATA_WIDTH  value to write (typically the ALU result).
- OperandA  output  DATA_WIDTH  registered operand A to the ALU.
- OperandB  output  DATA_WIDTH  registered operand B to the ALU.
- OpValid  output  1  OperandA/OperandB hold a freshly fetched pair.
- Hazard  output  1  read was refused (scoreboard only; tied 0 otherwise).
- ReserveEn  input  1  mark WriteAddr-to-be busy (scoreboard only; ignored otherwise).
- ReserveAddr  input  ADDR_WIDTH  register to reserve (scoreboard only).

Behaviour:
- Reset (ResetN low, asynchronous): all registers = 0, OperandA = OperandB = 0, OpValid = 0, Hazard = 0, all busy bits = 0. Outputs go to these values immediately, without waiting for a clock edge.
- Reset release is synchronous to the next rising edge. The first operation is accepted on the first edge with ResetN high.
- R0 is hardwired to zero:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0, including under bypass.
- Write: on a rising edge with WriteEn = 1 and WriteAddr != 0, reg[WriteAddr] <= WriteData.
- Read latency is 1 cycle:
  - On an edge with ReadEn = 1 and Stall = 0: OperandA <= value(ReadAddr1), OperandB <= value(ReadAddr2), OpValid <= 1.
- Bypass (write-first): if WriteEn = 1, WriteAddr != 0 and WriteAddr equals a read address in the same cycle, that operand captures WriteData, not the old register value. Both operands bypass when both addresses match.
- Stall = 1:
  - OperandA, OperandB and OpValid hold their values; ReadEn is ignored.
  - Writes still complete.
  - A held operand is not refreshed by a later write; the issuing stage must re-read.
- ReadEn = 0 and Stall = 0: operands hold their values, and OpValid <= 0 on that edge.
- Simultaneous ReadEn and Stall: Stall wins, and the request is not consumed.
- Reset mid-operation: any pending operand pair is lost, OpValid = 0, register contents are cleared.
- Addresses are unsigned and always in range. No wrap logic is needed, since NUM_REGS = 2**ADDR_WIDTH.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_EN.
- With the macro defined:
  - Each register has a busy bit. On an edge with ReserveEn = 1 and ReserveAddr != 0, busy[ReserveAddr] <= 1.
  - A write to an address clears its busy bit on the same edge. If reserve and write hit the same address on the same edge, reserve wins.
  - A read request (ReadEn = 1, Stall = 0) whose source is busy, and is not being written this cycle, is refused: OpValid <= 0, Hazard <= 1, operands hold.
  - Hazard is registered and otherwise 0. R0 is never busy.
- Without the macro: ReserveEn and ReserveAddr are ignored, Hazard is constant 0, and no busy storage is built.

Test Plan:
- Reset then read: ResetN pulse, then ReadEn with addresses 1 and 2 -> next edge OperandA = 0x0000, OperandB = 0x0000, OpValid = 1.
- Write/read: write R1 = 0xBEEF and R2 = 0x1234, then read (1,2) -> OperandA = 0xBEEF, OperandB = 0x1234 one cycle after ReadEn.
- Bypass: R3 = 0x0001; same cycle WriteEn R3 = 0xA5A5 and ReadEn (3,3) -> OperandA = OperandB = 0xA5A5.
- R0 immunity: write R0 = 0xFFFF, read (0,0), including a same-cycle bypass attempt -> both operands 0x0000.
- Stall: OpValid = 1 with A = 0xBEEF; raise Stall for 3 cycles while writing R1 = 0x0F0F -> operands and OpValid unchanged. Drop Stall with ReadEn (1,1) -> operands = 0x0F0F.
- Async reset mid-operation: assert ResetN low between edges -> OpValid = 0 and operands = 0 before the next edge. With REGFILE_SCOREBOARD_EN: reserve R2, then read R2 -> Hazard = 1, OpValid = 0. Write R2 = 0x0042 together with a same-cycle read -> OperandB = 0x0042, OpValid = 1, Hazard = 0.
